// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequential instruction fetch from a combinational ROM into a
// 2-entry {pc, instr} queue, with a branch redirect that flushes the queue and an
// optional halt on HALT_OPCODE.
// Optional feature macro: FETCH_HALT_DETECT_EN enables halt detection. When it is
// undefined, HALT is unreachable and halted is tied low.
module fetch_sequencer #(
  parameter int unsigned             PC_WIDTH    = 8,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = 8'h00,
  parameter logic [INSTR_WIDTH-1:0]  HALT_OPCODE = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_en,
  input  logic                   branch_en,
  input  logic [PC_WIDTH-1:0]    branch_addr,
  output logic [PC_WIDTH-1:0]    rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   halted
);

  typedef enum logic [1:0] {IDLE, FETCH, STALL, HALT} state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = 1;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    e0_pc;
  logic [PC_WIDTH-1:0]    e1_pc;
  logic [INSTR_WIDTH-1:0] e0_instr;
  logic [INSTR_WIDTH-1:0] e1_instr;
  logic [1:0]             count;
  logic                   pop;
  logic                   push;
  logic                   halt_hit;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
  assign halted = (state == HALT);
`else
  localparam bit HALT_EN = 1'b0;
  assign halted = 1'b0;
`endif

  assign rom_addr  = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = e0_pc;
  assign out_instr = e0_instr;

  // Handshake and fetch qualifiers for the current cycle.
  always_comb begin
    pop      = (count != 2'd0) && out_ready;
    push     = (state == FETCH) && run_en && !branch_en && ((count != 2'd2) || pop);
    halt_hit = HALT_EN && (rom_data == HALT_OPCODE);
  end

  // FSM, PC and queue state; branch flushes the queue, so a pop in that cycle
  // is simply absorbed by the flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      count    <= '0;
      e0_pc    <= '0;
      e0_instr <= '0;
      e1_pc    <= '0;
      e1_instr <= '0;
    end else if (branch_en) begin
      count <= '0;
      pc    <= branch_addr;
      state <= run_en ? FETCH : IDLE;
    end else begin
      if (pop && push) begin
        if (count == 2'd2) begin
          e0_pc    <= e1_pc;
          e0_instr <= e1_instr;
          e1_pc    <= pc;
          e1_instr <= rom_data;
        end else begin
          e0_pc    <= pc;
          e0_instr <= rom_data;
        end
      end else if (pop) begin
        e0_pc    <= e1_pc;
        e0_instr <= e1_instr;
        count    <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) begin
          e0_pc    <= pc;
          e0_instr <= rom_data;
        end else begin
          e1_pc    <= pc;
          e1_instr <= rom_data;
        end
        count <= count + 2'd1;
      end

      if (push && !halt_hit)
        pc <= pc + PC_STEP;

      case (state)
        IDLE:    if (run_en) state <= FETCH;
        FETCH: begin
          if (!run_en)
            state <= IDLE;
          else if (push && halt_hit)
            state <= HALT;
          else if (!pop && ((count == 2'd2) || ((count == 2'd1) && push)))
            state <= STALL;
        end
        STALL: begin
          if (!run_en)
            state <= IDLE;
          else if (pop)
            state <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: ROM returns {24'h0, addr}, optionally FFFF_FFFF at
// address 03. A negedge monitor checks every handshake against a queue of
// expected {pc, instr} pairs.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_en = 1'b0;
  logic        branch_en = 1'b0;
  logic [7:0]  branch_addr = '0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic        halt_word = 1'b0;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [39:0] exp_q[$];

  fetch_sequencer #(
    .PC_WIDTH(8),
    .INSTR_WIDTH(32),
    .RESET_PC(8'h00),
    .HALT_OPCODE(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run_en(run_en),
    .branch_en(branch_en),
    .branch_addr(branch_addr),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  assign rom_data = (halt_word && rom_addr == 8'h03) ? 32'hFFFF_FFFF : {24'h0, rom_addr};

  // Scoreboard: every accepted entry must match the oldest expectation.
  always @(negedge clk) begin
    logic [39:0] e;
    if (!reset && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL handshake_unexpected: got pc=%h instr=%h, required none", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          fails++;
          $display("FAIL handshake_data: got pc=%h instr=%h, required pc=%h instr=%h",
                   out_pc, out_instr, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [7:0] p, input logic halt_at3);
    logic [31:0] w;
    w = (halt_at3 && p == 8'h03) ? 32'hFFFF_FFFF : {24'h0, p};
    exp_q.push_back({p, w});
  endtask

  task automatic do_reset();
    reset = 1'b1; run_en = 1'b0; branch_en = 1'b0; out_ready = 1'b0; halt_word = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_drained: got pending=%0d out_valid=%b, required 0 and 0", name, exp_q.size(), out_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run_en = 1'b1; out_ready = 1'b1;
    cyc(); cyc();
    tests++;
    if ({out_valid, halted, out_pc, out_instr, rom_addr} !== 50'h0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b h=%b pc=%h instr=%h addr=%h, required all zero",
               out_valid, halted, out_pc, out_instr, rom_addr);
    end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 10; i++) expect_pc(8'(i), 1'b0);
    run_en = 1'b1; out_ready = 1'b1;
    cyc();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_latency1: got out_valid=%b, required 0", out_valid); end
    cyc();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00) begin
      fails++; $display("FAIL stream_first: got v=%b pc=%h, required 1 00", out_valid, out_pc);
    end
    repeat (9) cyc();
    run_en = 1'b0;
    cyc();
    tests++;
    if (rom_addr !== 8'h0A) begin fails++; $display("FAIL stream_pc: got %h, required 0a", rom_addr); end
    check_drained("stream");
  endtask

  task automatic test_stall();
    do_reset();
    expect_pc(8'h00, 1'b0); expect_pc(8'h01, 1'b0); expect_pc(8'h02, 1'b0);
    run_en = 1'b1; out_ready = 1'b0;
    repeat (5) cyc();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00 || rom_addr !== 8'h02) begin
      fails++; $display("FAIL stall_hold: got v=%b pc=%h addr=%h, required 1 00 02", out_valid, out_pc, rom_addr);
    end
    out_ready = 1'b1;
    cyc();
    tests++;
    if (out_pc !== 8'h01) begin fails++; $display("FAIL stall_resume1: got %h, required 01", out_pc); end
    cyc();
    tests++;
    if (out_pc !== 8'h02) begin fails++; $display("FAIL stall_resume2: got %h, required 02", out_pc); end
    run_en = 1'b0;
    cyc();
    check_drained("stall");
  endtask

  task automatic test_branch();
    do_reset();
    run_en = 1'b1; out_ready = 1'b0;
    repeat (3) cyc();
    branch_en = 1'b1; branch_addr = 8'h40;
    cyc();
    tests++;
    if (out_valid !== 1'b0 || rom_addr !== 8'h40) begin
      fails++; $display("FAIL branch_flush: got v=%b addr=%h, required 0 40", out_valid, rom_addr);
    end
    branch_en = 1'b0; out_ready = 1'b1;
    expect_pc(8'h40, 1'b0); expect_pc(8'h41, 1'b0);
    cyc();
    tests++;
    if (out_pc !== 8'h40) begin fails++; $display("FAIL branch_first: got %h, required 40", out_pc); end
    cyc();
    run_en = 1'b0;
    cyc();
    check_drained("branch");
  endtask

  task automatic test_wrap();
    do_reset();
    run_en = 1'b1; out_ready = 1'b1; branch_en = 1'b1; branch_addr = 8'hFE;
    expect_pc(8'hFE, 1'b0); expect_pc(8'hFF, 1'b0); expect_pc(8'h00, 1'b0); expect_pc(8'h01, 1'b0);
    cyc();
    branch_en = 1'b0;
    repeat (4) cyc();
    run_en = 1'b0;
    cyc();
    tests++;
    if (rom_addr !== 8'h02) begin fails++; $display("FAIL wrap_pc: got %h, required 02", rom_addr); end
    check_drained("wrap");
  endtask

  task automatic test_halt();
    do_reset();
    halt_word = 1'b1; run_en = 1'b1; out_ready = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
    for (int i = 0; i < 4; i++) expect_pc(8'(i), 1'b1);
    repeat (5) cyc();
    tests++;
    if (halted !== 1'b1 || rom_addr !== 8'h03) begin
      fails++; $display("FAIL halt_enter: got h=%b addr=%h, required 1 03", halted, rom_addr);
    end
    repeat (3) cyc();
    tests++;
    if (halted !== 1'b1 || out_valid !== 1'b0 || rom_addr !== 8'h03) begin
      fails++; $display("FAIL halt_hold: got h=%b v=%b addr=%h, required 1 0 03", halted, out_valid, rom_addr);
    end
    branch_en = 1'b1; branch_addr = 8'h10;
    cyc();
    branch_en = 1'b0;
    tests++;
    if (halted !== 1'b0 || rom_addr !== 8'h10) begin
      fails++; $display("FAIL halt_exit: got h=%b addr=%h, required 0 10", halted, rom_addr);
    end
    expect_pc(8'h10, 1'b1);
    cyc();
    run_en = 1'b0;
    cyc();
`else
    for (int i = 0; i < 5; i++) expect_pc(8'(i), 1'b1);
    repeat (6) cyc();
    tests++;
    if (halted !== 1'b0 || rom_addr !== 8'h05) begin
      fails++; $display("FAIL halt_ignored: got h=%b addr=%h, required 0 05", halted, rom_addr);
    end
    run_en = 1'b0;
    cyc();
`endif
    check_drained("halt");
    halt_word = 1'b0;
  endtask

  task automatic test_reset_stall();
    do_reset();
    run_en = 1'b1; out_ready = 1'b0;
    repeat (4) cyc();
    reset = 1'b1; branch_en = 1'b1; branch_addr = 8'h55; out_ready = 1'b1;
    cyc();
    tests++;
    if (out_valid !== 1'b0 || rom_addr !== 8'h00 || halted !== 1'b0) begin
      fails++; $display("FAIL reset_stall: got v=%b addr=%h h=%b, required 0 00 0", out_valid, rom_addr, halted);
    end
    reset = 1'b0; branch_en = 1'b0; run_en = 1'b0;
    repeat (2) cyc();
    tests++;
    if (out_valid !== 1'b0 || rom_addr !== 8'h00) begin
      fails++; $display("FAIL reset_idle: got v=%b addr=%h, required 0 00", out_valid, rom_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
